// File: rtl/d_ff_pkg.sv
// Shared register-file types and constants for the d_ff storage bank.
package d_ff_pkg;
    localparam int DATA_W = 64;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/d_ff_mux2_1.sv
// Single-bit 2:1 multiplexer used in front of each storage flop.
module mux2_1 (
    output logic       out,
    input  logic [1:0] inputs,
    input  logic       select
);
    assign out = select ? inputs[1] : inputs[0];
endmodule

// File: rtl/d_ff.sv
// WIDTH-bit D flip-flop bank with per-bit hold/load mux and async active-low reset.
// Optional scan chain enabled by defining D_FF_SCAN_EN.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] d,
`ifdef D_FF_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] q_p0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_1 u_load_mux (
            .out    (load_d[i]),
            .inputs ({d[i], q_p0[i]}),
            .select (write_enable)
        );
`ifdef D_FF_SCAN_EN
        logic shift_bit;
        // Bit 0 takes scan_in; every other bit takes its lower neighbour.
        if (i == 0) begin : g_head
            assign shift_bit = scan_in;
        end else begin : g_link
            assign shift_bit = q_p0[i-1];
        end
        mux2_1 u_scan_mux (
            .out    (next_d[i]),
            .inputs ({shift_bit, load_d[i]}),
            .select (scan_en)
        );
`else
        assign next_d[i] = load_d[i];
`endif
    end

    // Stage p0: storage flops, clocked every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_p0 <= RESET_VALUE;
        end else begin
            q_p0 <= next_d;
        end
    end

    assign q = q_p0;
`ifdef D_FF_SCAN_EN
    assign scan_out = q_p0[WIDTH-1];
`endif
endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: scoreboard queue of expected q values.
module tb_d_ff;
    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] PAT  = 64'hA5A5_5A5A_0F0F_F0F0;

    logic         clk = 1'b0;
    logic         reset;
    logic         write_enable;
    logic [W-1:0] d;
    logic [W-1:0] q;
`ifdef D_FF_SCAN_EN
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] model;

    always #5 clk = ~clk;

    d_ff #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .d            (d),
`ifdef D_FF_SCAN_EN
        .scan_en      (scan_en),
        .scan_in      (scan_in),
        .scan_out     (scan_out),
`endif
        .q            (q)
    );

    task automatic test_reset();
        reset = 1'b0;
        write_enable = 1'b0;
        d = 'x;
        #2;
        tests++;
        if (q !== '0) begin
            fails++;
            $display("FAIL reset_immediate: got %h expected %h", q, {W{1'b0}});
        end
        write_enable = 1'b1;
        d = ONES;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('0);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            tests++;
            if (q !== exp_v) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, q, exp_v);
            end
        end
    endtask

    task automatic test_load();
        write_enable = 1'b1;
        d = ONES;
        reset = 1'b1;
        #1;
        tests++;
        if (q !== '0) begin
            fails++;
            $display("FAIL release_no_change: got %h expected %h", q, {W{1'b0}});
        end
        exp_q.push_back(ONES);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        tests++;
        if (q !== exp_v) begin
            fails++;
            $display("FAIL load_ones: got %h expected %h", q, exp_v);
        end
        d = '0;
        exp_q.push_back('0);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        tests++;
        if (q !== exp_v) begin
            fails++;
            $display("FAIL load_zeros: got %h expected %h", q, exp_v);
        end
    endtask

    task automatic test_hold();
        write_enable = 1'b0;
        d = ONES;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('0);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            tests++;
            if (q !== exp_v) begin
                fails++;
                $display("FAIL hold[%0d]: got %h expected %h", i, q, exp_v);
            end
        end
        write_enable = 1'b1;
        d = PAT;
        exp_q.push_back(PAT);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        tests++;
        if (q !== exp_v) begin
            fails++;
            $display("FAIL load_after_hold: got %h expected %h", q, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (q !== '0) begin
            fails++;
            $display("FAIL mid_reset: got %h expected %h", q, {W{1'b0}});
        end
        write_enable = 1'b1;
        d = 64'h1;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (q !== '0) begin
            fails++;
            $display("FAIL mid_release: got %h expected %h", q, {W{1'b0}});
        end
        exp_q.push_back(64'h1);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        tests++;
        if (q !== exp_v) begin
            fails++;
            $display("FAIL first_edge_after_release: got %h expected %h", q, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        model = 64'h1;
        for (int i = 0; i < 24; i++) begin
            write_enable = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            if (write_enable) model = d;
            exp_q.push_back(model);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            tests++;
            if (q !== exp_v) begin
                fails++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, q, exp_v);
            end
        end
    endtask

`ifdef D_FF_SCAN_EN
    task automatic test_scan();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model = '0;
        scan_en = 1'b1;
        scan_in = 1'b1;
        write_enable = 1'b1;
        d = PAT;
        for (int k = 1; k <= W; k++) begin
            model = {model[W-2:0], 1'b1};
            exp_q.push_back(model);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            tests++;
            if (q !== exp_v || scan_out !== exp_v[W-1]) begin
                fails++;
                $display("FAIL scan_shift[%0d]: got %h/%b expected %h/%b",
                         k, q, scan_out, exp_v, exp_v[W-1]);
            end
        end
        scan_en = 1'b0;
        exp_q.push_back(PAT);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        tests++;
        if (q !== exp_v) begin
            fails++;
            $display("FAIL scan_off_load: got %h expected %h", q, exp_v);
        end
        scan_en = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (q !== '0 || scan_out !== 1'b0) begin
            fails++;
            $display("FAIL scan_reset: got %h/%b expected 0/0", q, scan_out);
        end
        reset = 1'b1;
        scan_en = 1'b0;
    endtask
`endif

    initial begin
`ifdef D_FF_SCAN_EN
        scan_en = 1'b0;
        scan_in = 1'b0;
`endif
        test_reset();
        test_load();
        test_hold();
        test_mid_reset();
        test_back_to_back();
`ifdef D_FF_SCAN_EN
        test_scan();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
